delay_arbiter: RTL and testbench

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arb_pkg.sv | 16 +
 rtl/delay_arbiter_rr_pick.sv | 27 ++
 rtl/delay_arbiter.sv | 111 +++++++++++
 tb/tb_delay_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arb_pkg.sv
`default_nettype none
// delay_arb_pkg: FSM states and sizing limits shared by delay_arbiter and its bench.
package delay_arb_pkg;
  localparam int N_REQ_DEFAULT  = 4;
  localparam int TIME_W_DEFAULT = 12;
  localparam int N_REQ_MIN      = 2;
  localparam int N_REQ_MAX      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/delay_arbiter_rr_pick.sv
`default_nettype none
// rr_pick: one-hot selection of the first set req bit, searching upward from ptr with wrap.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner
);
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rot_first;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, take the lowest set bit, rotate back.
    rot = req;
    for (int p = 1; p < N_REQ; p++)
      if (ptr == PTR_W'(p))
        for (int i = 0; i < N_REQ; i++) rot[i] = req[(i + p) % N_REQ];
    rot_first = rot & (~rot + 1'b1);
    winner = rot_first;
    for (int p = 1; p < N_REQ; p++)
      if (ptr == PTR_W'(p))
        for (int i = 0; i < N_REQ; i++) winner[(i + p) % N_REQ] = rot_first[i];
  end
endmodule
`default_nettype wire

// File: rtl/delay_arbiter.sv
`default_nettype none
// delay_arbiter: shares one millisecond delay timer among N_REQ requesters (round-robin).
// Define DELAY_ARB_FIXED_PRIO_EN for fixed lowest-index-first selection.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int TIME_W = TIME_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TIME_W-1:0] req_time_ms,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [TIME_W-1:0]       tmr_time_ms,
  output logic                    tmr_start,
  input  logic                    tmr_done
);
  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("delay_arbiter: N_REQ outside legal range");
  end

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  winner;
  logic [TIME_W-1:0] win_time;
  logic              wait_first;
  logic              take;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  always_comb begin
    win_time = '0;
    for (int i = 0; i < N_REQ; i++)
      if (winner[i]) win_time = req_time_ms[i*TIME_W +: TIME_W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    tmr_start = 1'b0;
    done      = '0;
    case (state)
      IDLE: begin
        if (|req && tmr_done) begin
          take      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tmr_start = 1'b1;
        state_nxt = WAIT;
      end
      // The timer may still report ready on the first WAIT cycle before it sees the start.
      WAIT: begin
        if (!wait_first && tmr_done) state_nxt = DONE;
      end
      DONE: begin
        done      = grant & req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant       <= '0;
      tmr_time_ms <= '0;
      wait_first  <= 1'b0;
    end else begin
      wait_first <= (state == START);
      if (take) begin
        grant       <= winner;
        tmr_time_ms <= win_time;
      end else if (state == DONE) begin
        grant <= '0;
      end
    end
  end

`ifdef DELAY_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) ptr_nxt = PTR_W'((i + 1) % N_REQ);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               ptr <= '0;
    else if (state == DONE)  ptr <= ptr_nxt;
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_delay_arbiter.sv
`default_nettype none
// tb_delay_arbiter: randomized self-checking bench with a transaction-level arbitration model
// and a cycle-counting timer model that registers its start input.
module tb_delay_arbiter;
  localparam int N = 4;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_time_ms = '0;
  logic [N-1:0]   grant, done;
  logic [W-1:0]   tmr_time_ms;
  logic           tmr_start, tmr_done;

  int compared = 0;
  int mismatched = 0;
  int mptr = 0;

  // Timer model: sees start one cycle late, then stays busy for timer_cycles cycles.
  int   timer_cycles = 20;
  logic start_d = 1'b0;
  logic busy = 1'b0;
  int   cnt = 0;

  // Transaction record filled by collect()
  logic         t_timeout, t_start_ok, t_stable, t_same_grant;
  logic [N-1:0] t_g, t_done_v, t_done_after;
  logic [W-1:0] t_tstart;
  int           t_lat, t_start_len, t_td_cyc, t_last_cyc, t_done_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    start_d <= tmr_start;
    if (start_d) begin
      busy <= 1'b1;
      cnt  <= timer_cycles;
    end else if (busy) begin
      if (cnt <= 1) busy <= 1'b0;
      cnt <= cnt - 1;
    end
  end
  assign tmr_done = !busy && !tmr_start;

  delay_arbiter #(.N_REQ(N), .TIME_W(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .req_time_ms (req_time_ms),
    .grant       (grant),
    .done        (done),
    .tmr_time_ms (tmr_time_ms),
    .tmr_start   (tmr_start),
    .tmr_done    (tmr_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Reference selection: first requester at or after the pointer, wrapping upward.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int s;
`ifdef DELAY_ARB_FIXED_PRIO_EN
    s = 0 * p;
`else
    s = p;
`endif
    for (int k = 0; k < N; k++)
      if (r[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  // Waits for one grant and follows it to completion; optionally perturbs inputs on cycle 3.
  task automatic collect(input bit drop_winner, input logic [N-1:0] add_mask,
                         input bit chg_time, input logic [W-1:0] new_t0);
    int n;
    int cyc;
    t_timeout = 1'b0; t_g = '0; t_done_v = '0; t_done_cnt = 0; t_start_len = 0;
    t_stable = 1'b1; t_same_grant = 1'b1; t_td_cyc = -1; t_last_cyc = -1;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 200);
    t_lat = n;
    if (grant == '0) begin
      t_timeout = 1'b1;
      return;
    end
    t_g = grant; t_tstart = tmr_time_ms; t_start_ok = tmr_start;
    cyc = 0;
    while (grant != '0 && cyc < 200) begin
      if (tmr_start) t_start_len++;
      if (tmr_time_ms !== t_tstart) t_stable = 1'b0;
      if (grant !== t_g) t_same_grant = 1'b0;
      if (cyc >= 2 && t_td_cyc < 0 && tmr_done) t_td_cyc = cyc;
      if (done != '0) begin
        t_done_v = t_done_v | done;
        t_done_cnt++;
      end
      t_last_cyc = cyc;
      if (cyc == 3) begin
        if (drop_winner) req = req & ~t_g;
        req = req | add_mask;
        if (chg_time) req_time_ms[W-1:0] = new_t0;
      end
      tick();
      cyc++;
    end
    t_done_after = done;
    if (grant != '0) t_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    compared++; if (grant !== '0) begin mismatched++; $display("FAIL reset_grant: got %b want 0", grant); end
    compared++; if (done !== '0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (tmr_start !== 1'b0) begin mismatched++; $display("FAIL reset_start: got %b want 0", tmr_start); end
    compared++; if (tmr_time_ms !== '0) begin mismatched++; $display("FAIL reset_time: got %0d want 0", tmr_time_ms); end
    rstn = 1'b1;
    mptr = 0;
  endtask

  task automatic test_single();
    timer_cycles = 20;
    req_time_ms[W-1:0] = W'(5);
    req = 4'b0001;
    collect(1'b0, '0, 1'b0, '0);
    req = '0;
    compared++; if (t_timeout !== 1'b0) begin mismatched++; $display("FAIL single_timeout: got %b want 0", t_timeout); end
    compared++; if (t_lat != 1) begin mismatched++; $display("FAIL single_latency: got %0d want 1", t_lat); end
    compared++; if (t_g !== 4'b0001) begin mismatched++; $display("FAIL single_grant: got %b want 0001", t_g); end
    compared++; if (!t_start_ok || t_start_len != 1) begin mismatched++; $display("FAIL single_start: first=%b len=%0d want 1/1", t_start_ok, t_start_len); end
    compared++; if (t_tstart !== W'(5)) begin mismatched++; $display("FAIL single_time: got %0d want 5", t_tstart); end
    compared++; if (t_last_cyc != t_td_cyc + 1) begin mismatched++; $display("FAIL single_done_timing: done cycle %0d want %0d", t_last_cyc, t_td_cyc + 1); end
    compared++; if (t_done_v !== 4'b0001 || t_done_cnt != 1) begin mismatched++; $display("FAIL single_done: got %b x%0d want 0001 x1", t_done_v, t_done_cnt); end
    compared++; if (t_done_after !== '0) begin mismatched++; $display("FAIL single_done_idle: got %b want 0", t_done_after); end
    mptr = 1;
  endtask

`ifdef DELAY_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int e;
    timer_cycles = 2;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      e = pick(req, mptr);
      collect(1'b0, '0, 1'b0, '0);
      compared++; if (t_g !== onehot(e)) begin mismatched++; $display("FAIL fixed_grant: got %b want %b", t_g, onehot(e)); end
      compared++; if (t_g[3] !== 1'b0) begin mismatched++; $display("FAIL fixed_no_bit3: got %b want bit3 clear", t_g); end
    end
    req = '0;
  endtask
`else
  task automatic test_round_robin();
    int e;
    rstn = 1'b0; tick(); rstn = 1'b1;
    mptr = 0;
    timer_cycles = 2;
    for (int i = 0; i < N; i++) req_time_ms[i*W +: W] = W'(i + 1);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      e = pick(req, mptr);
      collect(1'b0, '0, 1'b0, '0);
      compared++; if (t_g !== onehot(e)) begin mismatched++; $display("FAIL rr_grant: got %b want %b", t_g, onehot(e)); end
      compared++; if (t_done_v !== onehot(e) || t_done_cnt != 1) begin mismatched++; $display("FAIL rr_done: got %b x%0d want %b x1", t_done_v, t_done_cnt, onehot(e)); end
      compared++; if (t_lat != 1) begin mismatched++; $display("FAIL rr_latency: got %0d want 1", t_lat); end
      mptr = (e + 1) % N;
    end
    req = '0;
  endtask
`endif

  task automatic test_abandon();
    int e;
    timer_cycles = 6;
    req_time_ms[2*W +: W] = W'(3);
    req = 4'b0100;
    collect(1'b1, 4'b0001, 1'b0, '0);
    compared++; if (t_g !== 4'b0100) begin mismatched++; $display("FAIL abandon_grant: got %b want 0100", t_g); end
    compared++; if (t_done_v !== '0 || t_done_cnt != 0) begin mismatched++; $display("FAIL abandon_done: got %b x%0d want 0000", t_done_v, t_done_cnt); end
    compared++; if (t_last_cyc != t_td_cyc + 1) begin mismatched++; $display("FAIL abandon_run: end cycle %0d want %0d", t_last_cyc, t_td_cyc + 1); end
    mptr = 3;
    e = pick(4'b0001, mptr);
    collect(1'b0, '0, 1'b0, '0);
    req = '0;
    compared++; if (t_g !== onehot(e) || t_lat != 1) begin mismatched++; $display("FAIL abandon_next: got %b lat %0d want %b lat 1", t_g, t_lat, onehot(e)); end
    mptr = (e + 1) % N;
  endtask

  task automatic test_time_latch();
    timer_cycles = 8;
    req_time_ms[W-1:0] = W'(7);
    req = 4'b0001;
    collect(1'b0, '0, 1'b1, W'(9));
    req = '0;
    compared++; if (t_tstart !== W'(7)) begin mismatched++; $display("FAIL latch_start: got %0d want 7", t_tstart); end
    compared++; if (t_stable !== 1'b1) begin mismatched++; $display("FAIL latch_hold: got unstable want 7 through DONE"); end
    compared++; if (t_done_v !== 4'b0001) begin mismatched++; $display("FAIL latch_done: got %b want 0001", t_done_v); end
    mptr = 1;
  endtask

  task automatic test_zero_delay();
    int j;
    j = int'($urandom_range(0, N - 1));
    timer_cycles = 1;
    req_time_ms[j*W +: W] = '0;
    req = onehot(j);
    collect(1'b0, '0, 1'b0, '0);
    req = '0;
    compared++; if (t_g !== onehot(j) || t_tstart !== '0) begin mismatched++; $display("FAIL zero_delay: got %b/%0d want %b/0", t_g, t_tstart, onehot(j)); end
    mptr = (j + 1) % N;
  endtask

  task automatic test_random();
    int e;
    bit drop;
    logic [W-1:0] exp_t;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++) req_time_ms[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      timer_cycles = int'($urandom_range(1, 8));
      drop = ($urandom_range(0, 3) == 0);
      req = N'($urandom_range(1, (1 << N) - 1));
      e = pick(req, mptr);
      exp_t = req_time_ms[e*W +: W];
      collect(drop, '0, 1'b0, '0);
      compared++;
      if (t_timeout || t_g !== onehot(e) || t_tstart !== exp_t || !t_same_grant) begin
        mismatched++;
        $display("FAIL rand_grant[%0d]: got %b/%0d want %b/%0d", k, t_g, t_tstart, onehot(e), exp_t);
      end
      compared++;
      if (t_done_v !== (drop ? '0 : onehot(e)) || t_last_cyc != t_td_cyc + 1 || t_start_len != 1) begin
        mismatched++;
        $display("FAIL rand_done[%0d]: got %b end %0d starts %0d want %b end %0d starts 1",
                 k, t_done_v, t_last_cyc, t_start_len, drop ? '0 : onehot(e), t_td_cyc + 1);
      end
      mptr = (e + 1) % N;
    end
    req = '0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit quiet;
    rstn = 1'b0; tick(); rstn = 1'b1;
    mptr = 0;
    timer_cycles = 30;
    req_time_ms[W-1:0] = W'(11);
    req = 4'b0001;
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < 50);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    compared++; if (grant !== '0 || done !== '0) begin mismatched++; $display("FAIL midreset_grant: got %b/%b want 0/0", grant, done); end
    compared++; if (tmr_start !== 1'b0 || tmr_time_ms !== '0) begin mismatched++; $display("FAIL midreset_timer: got %b/%0d want 0/0", tmr_start, tmr_time_ms); end
    tick();
    rstn = 1'b1;
    quiet = 1'b1;
    n = 0;
    while (!tmr_done && n < 100) begin
      if (grant !== '0) quiet = 1'b0;
      tick();
      n++;
    end
    compared++; if (!quiet || n >= 100) begin mismatched++; $display("FAIL midreset_hold: quiet=%b cycles=%0d want quiet and timer idle", quiet, n); end
    tick();
    compared++; if (grant !== 4'b0001 || tmr_start !== 1'b1 || tmr_time_ms !== W'(11)) begin mismatched++; $display("FAIL midreset_regrant: got %b/%b/%0d want 0001/1/11", grant, tmr_start, tmr_time_ms); end
    n = 0;
    while (grant != '0 && n < 200) begin tick(); n++; end
    req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
`ifdef DELAY_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_abandon();
    test_time_latch();
    test_zero_delay();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
